dmem_port_arbiter: RTL
======================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port 16-bit data memory between two requesters: port A (core load/store
//  stage) and port B (DMA/loader). Grants one access per cycle, drives the memory's shared
//  address/write/read pins, and returns registered read data with a valid strobe.
//  Sits between the core/DMA and the data memory; the memory itself is unchanged.
// PARAMETERS
//  AW         16  address width (memory decodes low bits only)
//  DW         16  data width
//  MAX_BURST  4   max consecutive B grants while A is requesting (1..15)
// PORTS
//  clk             in   1   single clock; all state on posedge
//  rst_n           in   1   asynchronous active-low reset
//  a_req           in   1   A access request; held until a_gnt
//  a_we            in   1   A write (1) / read (0)
//  a_addr          in   AW  A address
//  a_wdata         in   DW  A write data
//  a_gnt           out  1   A granted this cycle (combinational)
//  a_rdata         out  DW  A read data, valid with a_rvalid
//  a_rvalid        out  1   A read data valid, 1 cycle after read grant
//  b_req,b_we,b_addr,b_wdata,b_gnt,b_rdata,b_rvalid   same as A, for port B
//  b_lock          in   1   B requests sticky ownership (burst)
//  mem_access_addr out  AW  to memory
//  mem_write_data  out  DW  to memory
//  mem_write_en    out  1   to memory
//  mem_read        out  1   to memory
//  mem_read_data   in   DW  from memory (combinational read)
// BEHAVIOUR
//  - Reset: state IDLE, burst_cnt=0, last=B (A wins first tie), a/b_rvalid=0, a/b_rdata=0.
//    a/b_gnt and mem_* outputs are combinational; with no req they are 0.
//  - FSM owner state: IDLE, OWN_A, OWN_B. Next state = port granted this cycle; IDLE if none.
//  - Arbitration each cycle:
//    * only one req -> grant it.
//    * both req, state OWN_B, b_lock=1, burst_cnt<MAX_BURST -> grant B.
//    * both req otherwise -> round-robin: grant port != last.
//  - burst_cnt: +1 on each B grant while a_req=1; clears on any A grant or IDLE cycle;
//    saturates at MAX_BURST. Guarantees A served within MAX_BURST+1 cycles.
//  - Granted port drives mem_access_addr/mem_write_data; mem_write_en=gnt&we; mem_read=gnt&~we.
//    Idle cycle: mem_* all 0.
//  - Write completes at the grant edge (memory writes on that posedge). No rvalid for writes.
//  - Read: mem_read_data captured into x_rdata at grant-cycle posedge; x_rvalid=1 next cycle
//    for exactly one cycle. x_rdata holds until next read of that port.
//  - Back-to-back reads on one port: rvalid each cycle, pipelined, no bubbles.
//  - Requester may change addr/we only after gnt; dropping req before gnt is legal (no access).
//  - Reset mid-operation: pending rvalid is discarded, FSM to IDLE, no memory write that cycle
//    (gnt forced 0 while rst_n=0).
// CONFIGURATION
//  DMEM_ARB_PERF_EN defined: adds outputs perf_conflicts[15:0] (cycles with a_req&b_req),
//  perf_a_grants[15:0], perf_b_grants[15:0]; wrap-around counters, reset to 0.
//  Undefined: ports and counters absent; arbitration identical.
// STRUCTURE
//  - Shared package/header (alongside Parameter.v): owner-state encodings
//    (ARB_IDLE=2'd0, ARB_OWN_A=2'd1, ARB_OWN_B=2'd2), default DW/AW, MAX_BURST default.
//  - One sub-module: dmem_rr_picker (2-way round-robin + lock/burst override, pure comb).
//  - Top holds FSM, burst counter, read-return registers, optional perf counters.
// TESTING
//  1 Reset: assert rst_n=0 mid-read -> rvalid=0, state IDLE, mem_write_en=0 throughout.
//  2 A read only: a_req, a_addr=3, mem[3]=16'h00A5 -> a_gnt same cycle, a_rvalid next cycle,
//    a_rdata=16'h00A5.
//  3 Both write same cycle, last=B: A writes addr 1=16'h1111 first, B addr 2=16'h2222 next cycle.
//  4 Both read continuously, no lock -> grants alternate A,B,A,B; each rvalid 1 cycle after gnt.
//  5 b_lock=1, both req, MAX_BURST=4 -> B granted 4 consecutive, then A, burst_cnt cleared.
//  6 PERF_EN: 10 cycles both req -> perf_conflicts=10, perf_a_grants+perf_b_grants=10.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: owner-state encoding,
// default widths and the burst limit.
package dmem_port_arbiter_pkg;

  localparam int DEF_AW        = 16;
  localparam int DEF_DW        = 16;
  localparam int DEF_MAX_BURST = 4;
  localparam int BURST_W       = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN_A = 2'd1,
    ARB_OWN_B = 2'd2
  } arb_state_e;

  // Increment that sticks at the limit instead of wrapping.
  function automatic logic [BURST_W-1:0] sat_inc(input logic [BURST_W-1:0] cnt,
                                                 input logic [BURST_W-1:0] limit);
    if (cnt >= limit) begin
      sat_inc = limit;
    end else begin
      sat_inc = cnt + 4'd1;
    end
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of both requester ports plus the shared memory pins.
// The slave modport is the arbiter's view; master is the requesters/memory side.
interface dmem_port_arbiter_if #(
  parameter int AW = dmem_port_arbiter_pkg::DEF_AW,
  parameter int DW = dmem_port_arbiter_pkg::DEF_DW
);
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic [DW-1:0] a_rdata;
  logic          a_rvalid;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic [DW-1:0] b_rdata;
  logic          b_rvalid;
  logic          b_lock;

  logic [AW-1:0] mem_access_addr;
  logic [DW-1:0] mem_write_data;
  logic          mem_write_en;
  logic          mem_read;
  logic [DW-1:0] mem_read_data;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata, b_lock,
    input  mem_read_data,
    output a_gnt, a_rdata, a_rvalid,
    output b_gnt, b_rdata, b_rvalid,
    output mem_access_addr, mem_write_data, mem_write_en, mem_read
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata, b_lock,
    output mem_read_data,
    input  a_gnt, a_rdata, a_rvalid,
    input  b_gnt, b_rdata, b_rvalid,
    input  mem_access_addr, mem_write_data, mem_write_en, mem_read
  );
endinterface

// File: rtl/dmem_rr_picker.sv
// Two-way round-robin pick with a B-lock override that holds B while its
// burst budget lasts. Purely combinational.
module dmem_rr_picker (
  input  logic a_req,
  input  logic b_req,
  input  logic b_lock,
  input  logic own_b,
  input  logic burst_ok,
  input  logic last_b,
  output logic pick_a,
  output logic pick_b
);

  // Select at most one port; on a tie the port not served last wins unless B holds a lock.
  always_comb begin
    pick_a = 1'b0;
    pick_b = 1'b0;
    if (a_req && b_req) begin
      if (own_b && b_lock && burst_ok) begin
        pick_b = 1'b1;
      end else if (last_b) begin
        pick_a = 1'b1;
      end else begin
        pick_b = 1'b1;
      end
    end else if (a_req) begin
      pick_a = 1'b1;
    end else if (b_req) begin
      pick_b = 1'b1;
    end else begin
      pick_a = 1'b0;
      pick_b = 1'b0;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one single-port data memory between port A (core) and port B (DMA).
// Optional performance counters are built when DMEM_ARB_PERF_EN is defined.
module dmem_port_arbiter #(
  parameter int AW        = dmem_port_arbiter_pkg::DEF_AW,
  parameter int DW        = dmem_port_arbiter_pkg::DEF_DW,
  parameter int MAX_BURST = dmem_port_arbiter_pkg::DEF_MAX_BURST
) (
  input logic clk,
  input logic rst_n,
`ifdef DMEM_ARB_PERF_EN
  output logic [15:0] perf_conflicts,
  output logic [15:0] perf_a_grants,
  output logic [15:0] perf_b_grants,
`endif
  dmem_port_arbiter_if.slave bus
);
  import dmem_port_arbiter_pkg::*;

  localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

  arb_state_e           state_r;
  arb_state_e           state_nxt_s;
  logic [BURST_W-1:0]   burst_cnt_r;
  logic                 last_b_r;
  logic                 pick_a_s;
  logic                 pick_b_s;
  logic                 gnt_a_s;
  logic                 gnt_b_s;
  logic [AW-1:0]        addr_s;
  logic [DW-1:0]        wdata_s;
  logic                 we_s;
  logic                 rd_s;
  logic                 a_rvalid_r;
  logic                 b_rvalid_r;
  logic [DW-1:0]        a_rdata_r;
  logic [DW-1:0]        b_rdata_r;

  dmem_rr_picker u_picker (
    .a_req    (bus.a_req),
    .b_req    (bus.b_req),
    .b_lock   (bus.b_lock),
    .own_b    (state_r == ARB_OWN_B),
    .burst_ok (burst_cnt_r < MAX_B),
    .last_b   (last_b_r),
    .pick_a   (pick_a_s),
    .pick_b   (pick_b_s)
  );

  // Grants are suppressed while reset is held so no access can slip through.
  assign gnt_a_s = pick_a_s & rst_n;
  assign gnt_b_s = pick_b_s & rst_n;

  // Next owner and the shared memory pins driven from whichever port is granted.
  always_comb begin
    state_nxt_s = ARB_IDLE;
    addr_s      = '0;
    wdata_s     = '0;
    we_s        = 1'b0;
    rd_s        = 1'b0;
    if (gnt_a_s) begin
      state_nxt_s = ARB_OWN_A;
      addr_s      = bus.a_addr;
      wdata_s     = bus.a_wdata;
      we_s        = bus.a_we;
      rd_s        = ~bus.a_we;
    end else if (gnt_b_s) begin
      state_nxt_s = ARB_OWN_B;
      addr_s      = bus.b_addr;
      wdata_s     = bus.b_wdata;
      we_s        = bus.b_we;
      rd_s        = ~bus.b_we;
    end else begin
      state_nxt_s = ARB_IDLE;
    end
  end

  // Owner state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Burst budget only drains while A is actually waiting behind B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_r <= '0;
      last_b_r    <= 1'b1;
    end else if (gnt_a_s) begin
      burst_cnt_r <= '0;
      last_b_r    <= 1'b0;
    end else if (gnt_b_s) begin
      burst_cnt_r <= bus.a_req ? sat_inc(burst_cnt_r, MAX_B) : burst_cnt_r;
      last_b_r    <= 1'b1;
    end else begin
      burst_cnt_r <= '0;
    end
  end

  // Read return: capture at the grant edge, strobe valid for the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid_r <= 1'b0;
      b_rvalid_r <= 1'b0;
      a_rdata_r  <= '0;
      b_rdata_r  <= '0;
    end else begin
      a_rvalid_r <= gnt_a_s & ~bus.a_we;
      b_rvalid_r <= gnt_b_s & ~bus.b_we;
      if (gnt_a_s && !bus.a_we) a_rdata_r <= bus.mem_read_data;
      if (gnt_b_s && !bus.b_we) b_rdata_r <= bus.mem_read_data;
    end
  end

  assign bus.a_gnt           = gnt_a_s;
  assign bus.b_gnt           = gnt_b_s;
  assign bus.mem_access_addr = addr_s;
  assign bus.mem_write_data  = wdata_s;
  assign bus.mem_write_en    = we_s;
  assign bus.mem_read        = rd_s;
  assign bus.a_rvalid        = a_rvalid_r;
  assign bus.b_rvalid        = b_rvalid_r;
  assign bus.a_rdata         = a_rdata_r;
  assign bus.b_rdata         = b_rdata_r;

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] conf_cnt_r;
  logic [15:0] a_cnt_r;
  logic [15:0] b_cnt_r;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conf_cnt_r <= 16'd0;
      a_cnt_r    <= 16'd0;
      b_cnt_r    <= 16'd0;
    end else begin
      if (bus.a_req && bus.b_req) conf_cnt_r <= conf_cnt_r + 16'd1;
      if (gnt_a_s) a_cnt_r <= a_cnt_r + 16'd1;
      if (gnt_b_s) b_cnt_r <= b_cnt_r + 16'd1;
    end
  end

  assign perf_conflicts = conf_cnt_r;
  assign perf_a_grants  = a_cnt_r;
  assign perf_b_grants  = b_cnt_r;
`endif

endmodule
